// File: rtl/conv_encoder_param.sv
// Rate-1/2 feed-forward convolutional encoder, parametrised constraint length and generators.
// Valid/ready on both sides, one-deep output register, optional zero-tail trellis termination per frame.
`timescale 1ns/1ps
module conv_encoder_param #(
  parameter int          K       = 3,
  parameter logic [K-1:0] G0     = 3'b101,
  parameter logic [K-1:0] G1     = 3'b111,
  parameter bit          TAIL_EN = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  input  logic in_last,
  output logic out_valid,
  input  logic out_ready,
  output logic out_c0,
  output logic out_c1,
  output logic out_last
);

  localparam int CW = (K > 2) ? $clog2(K) : 1;
  localparam logic [CW-1:0] TAIL_LAST = CW'(K - 2);

  typedef enum logic {S_DATA, S_TAIL} state_t;

  state_t state_reg, state_next;

  // Only the K-1 most recent bits are stored; the oldest tap of the window
  // is hist_reg[K-2], the newest is the bit being shifted in this cycle.
  logic [K-2:0]  hist_reg, hist_next;
  logic [K-1:0]  sr_win;
  logic [CW-1:0] tail_cnt_reg, tail_cnt_next;
  logic          out_valid_reg, out_valid_next;
  logic          c0_reg, c0_next;
  logic          c1_reg, c1_next;
  logic          last_reg, last_next;
  logic          slot_free;
  logic          shift_bit;
  logic          load;

  assign out_valid = out_valid_reg;
  assign out_c0    = c0_reg;
  assign out_c1    = c1_reg;
  assign out_last  = last_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_DATA;
      hist_reg      <= '0;
      tail_cnt_reg  <= '0;
      out_valid_reg <= 1'b0;
      c0_reg        <= 1'b0;
      c1_reg        <= 1'b0;
      last_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      hist_reg      <= hist_next;
      tail_cnt_reg  <= tail_cnt_next;
      out_valid_reg <= out_valid_next;
      c0_reg        <= c0_next;
      c1_reg        <= c1_next;
      last_reg      <= last_next;
    end
  end

  always_comb begin
    slot_free      = !out_valid_reg || out_ready;
    in_ready       = (state_reg == S_DATA) && slot_free;
    shift_bit      = (state_reg == S_DATA) ? in_bit : 1'b0;
    sr_win         = {hist_reg, shift_bit};
    load           = 1'b0;
    state_next     = state_reg;
    hist_next      = hist_reg;
    tail_cnt_next  = tail_cnt_reg;
    out_valid_next = out_valid_reg && !out_ready;
    c0_next        = c0_reg;
    c1_next        = c1_reg;
    last_next      = last_reg;

    case (state_reg)
      S_DATA: begin
        if (in_valid && in_ready) begin
          load      = 1'b1;
          hist_next = sr_win[K-2:0];
          last_next = 1'b0;
          if (in_last) begin
            if (TAIL_EN) begin
              state_next    = S_TAIL;
              tail_cnt_next = '0;
            end else begin
              // Untailed frame: drop history so the next frame starts from the zero state.
              last_next = 1'b1;
              hist_next = '0;
            end
          end
        end
      end
      S_TAIL: begin
        if (slot_free) begin
          load          = 1'b1;
          hist_next     = sr_win[K-2:0];
          tail_cnt_next = tail_cnt_reg + 1'b1;
          last_next     = 1'b0;
          if (tail_cnt_reg == TAIL_LAST) begin
            last_next     = 1'b1;
            state_next    = S_DATA;
            tail_cnt_next = '0;
          end
        end
      end
      default: state_next = S_DATA;
    endcase

    if (load) begin
      out_valid_next = 1'b1;
      c0_next        = ^(sr_win & G0);
      c1_next        = ^(sr_win & G1);
    end
  end

endmodule

// File: tb/tb_conv_encoder_param.sv
// Bench for conv_encoder_param: three configurations checked against a convolution model,
// directed frames with literal expectations, back-pressure, reset mid-tail and random traffic.
`timescale 1ns/1ps
module tb_conv_encoder_param;

  localparam int NI = 3;
  localparam int KS  [NI] = '{3, 7, 3};
  localparam int G0S [NI] = '{5, 121, 5};
  localparam int G1S [NI] = '{7, 91, 7};
  localparam int TLS [NI] = '{1, 1, 0};

  logic clk = 1'b0;
  logic reset;
  logic iv [NI];
  logic ib [NI];
  logic il [NI];
  logic ordy [NI];
  logic ir [NI];
  logic ov [NI];
  logic c0 [NI];
  logic c1 [NI];
  logic ol [NI];

  int         checks = 0;
  int         errors = 0;
  logic [2:0] expq [NI][$];
  int         popped [NI];
  bit         held_v [NI];
  logic [2:0] held [NI];
  bit         rnd_mode;
  bit         ordy_cmd [NI];

  always #5 clk = ~clk;

  conv_encoder_param #(.K(3), .G0(3'b101), .G1(3'b111), .TAIL_EN(1'b1)) dut0 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_bit(ib[0]),
    .in_last(il[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_c0(c0[0]),
    .out_c1(c1[0]), .out_last(ol[0]));

  conv_encoder_param #(.K(7), .G0(7'b1111001), .G1(7'b1011011), .TAIL_EN(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_bit(ib[1]),
    .in_last(il[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_c0(c0[1]),
    .out_c1(c1[1]), .out_last(ol[1]));

  conv_encoder_param #(.K(3), .G0(3'b101), .G1(3'b111), .TAIL_EN(1'b0)) dut2 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .in_bit(ib[2]),
    .in_last(il[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_c0(c0[2]),
    .out_c1(c1[2]), .out_last(ol[2]));

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d got=%b required=%b", name, idx, act, exp);
    end
  endtask

  // Reference: each coded bit is the GF(2) convolution of the frame (zero-padded) with the generator.
  task automatic model_frame(input int idx, input bit bits[$], output logic [2:0] res[$]);
    int k, n, total, g0, g1;
    bit a, b;
    k = KS[idx];
    g0 = G0S[idx];
    g1 = G1S[idx];
    n = bits.size();
    total = n + ((TLS[idx] != 0) ? k - 1 : 0);
    res.delete();
    for (int t = 0; t < total; t++) begin
      a = 1'b0;
      b = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (t - j >= 0 && t - j < n) begin
          a ^= g0[j] & bits[t-j];
          b ^= g1[j] & bits[t-j];
        end
      end
      res.push_back({a, b, (t == total - 1)});
    end
  endtask

  task automatic check_model(input string name, input logic [2:0] got[$], input logic [2:0] lit[$]);
    checks++;
    if (got.size() != lit.size()) begin
      errors++;
      $display("FAIL %s_len got=%0d required=%0d", name, got.size(), lit.size());
    end else begin
      foreach (lit[j]) begin
        checks++;
        if (got[j] !== lit[j]) begin
          errors++;
          $display("FAIL %s[%0d] got=%b required=%b", name, j, got[j], lit[j]);
        end
      end
    end
  endtask

  task automatic send_frame(input int idx, input bit bits[$], input bit gaps);
    logic [2:0] m[$];
    int n;
    model_frame(idx, bits, m);
    foreach (m[j]) expq[idx].push_back(m[j]);
    for (int b = 0; b < bits.size(); b++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        iv[idx] = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      iv[idx] = 1'b1;
      ib[idx] = bits[b];
      il[idx] = (b == bits.size() - 1);
      n = 0;
      forever begin
        @(negedge clk);
        if (ir[idx]) break;
        n++;
        if (n > 200) break;
      end
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL in_timeout inst%0d got=stalled required=accept", idx);
        iv[idx] = 1'b0;
        il[idx] = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    iv[idx] = 1'b0;
    il[idx] = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((expq[0].size() + expq[1].size() + expq[2].size()) != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if ((expq[0].size() + expq[1].size() + expq[2].size()) != 0) begin
      errors++;
      $display("FAIL drain got=%0d,%0d,%0d pending required=0", expq[0].size(), expq[1].size(), expq[2].size());
      for (int i = 0; i < NI; i++) expq[i].delete();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_frames(input int idx);
    bit q[$];
    for (int f = 0; f < 12; f++) begin
      int len;
      len = $urandom_range(1, 10);
      q.delete();
      for (int b = 0; b < len; b++) q.push_back(1'($urandom_range(0, 1)));
      send_frame(idx, q, 1'b1);
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NI; i++)
      ordy[i] = rnd_mode ? ($urandom_range(0, 3) != 0) : ordy_cmd[i];
  end

  // Single compare process: every output handshake, hold stability and in_ready rule.
  always @(negedge clk) begin
    logic [2:0] cur;
    logic [2:0] e;
    if (reset) begin
      for (int i = 0; i < NI; i++) held_v[i] = 1'b0;
    end else begin
      for (int i = 0; i < NI; i++) begin
        cur = {c0[i], c1[i], ol[i]};
        if (held_v[i]) chk("hold", i, {ov[i], cur}, {1'b1, held[i]});
        if (ov[i] && ordy[i]) begin
          if (expq[i].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_sym inst%0d got=%b required=none", i, cur);
          end else begin
            e = expq[i].pop_front();
            $display("sym inst%0d c0=%b c1=%b last=%b exp=%b", i, cur[2], cur[1], cur[0], e);
            chk("sym", i, {1'b0, cur}, {1'b0, e});
          end
          popped[i]++;
          held_v[i] = 1'b0;
        end else if (ov[i]) begin
          held_v[i] = 1'b1;
          held[i] = cur;
          chk("rdy_stall", i, {3'b0, ir[i]}, 4'b0000);
        end else begin
          held_v[i] = 1'b0;
          chk("rdy_idle", i, {3'b0, ir[i]}, 4'b0001);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit q[$];
    logic [2:0] m[$];
    logic [2:0] lit[$];
    reset = 1'b1;
    rnd_mode = 1'b0;
    for (int i = 0; i < NI; i++) begin
      iv[i] = 1'b0; ib[i] = 1'b0; il[i] = 1'b0; ordy_cmd[i] = 1'b1; popped[i] = 0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_state", i, {ov[i], c0[i], c1[i], ol[i]}, 4'b0000);
      chk("rst_rdy", i, {3'b0, ir[i]}, 4'b0001);
    end
    #2 reset = 1'b0;
    @(posedge clk); #1;

    // T1: K=3 tailed frame 1,0,1,1
    q = '{1'b1, 1'b0, 1'b1, 1'b1};
    model_frame(0, q, m);
    lit = '{3'b110, 3'b010, 3'b000, 3'b100, 3'b100, 3'b111};
    check_model("t1_model", m, lit);
    send_frame(0, q, 1'b0);
    wait_drain();

    // T2: single-bit frames back to back
    q = '{1'b1};
    model_frame(0, q, m);
    lit = '{3'b110, 3'b010, 3'b111};
    check_model("t2_model", m, lit);
    send_frame(0, q, 1'b0);
    send_frame(0, q, 1'b0);
    wait_drain();

    // T3: T1 with downstream stalled on the second symbol
    q = '{1'b1, 1'b0, 1'b1, 1'b1};
    fork
      send_frame(0, q, 1'b0);
      begin
        int p0, n;
        p0 = popped[0];
        n = 0;
        while (popped[0] == p0 && n < 100) begin
          @(negedge clk); #1;
          n++;
        end
        @(posedge clk);
        ordy_cmd[0] = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk("t3_hold", 0, {ov[0], c0[0], c1[0], ir[0]}, 4'b1010);
        end
        ordy_cmd[0] = 1'b1;
      end
    join
    wait_drain();

    // T4: K=7 impulse response then six zero tail symbols
    q = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    model_frame(1, q, m);
    lit = '{3'b110, 3'b010, 3'b000, 3'b110, 3'b110, 3'b100, 3'b110,
            3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b001};
    check_model("t4_model", m, lit);
    send_frame(1, q, 1'b0);
    wait_drain();

    // T5: untailed frames, history cleared between frames
    q = '{1'b1, 1'b1};
    model_frame(2, q, m);
    lit = '{3'b110, 3'b101};
    check_model("t5a_model", m, lit);
    send_frame(2, q, 1'b0);
    q = '{1'b1};
    model_frame(2, q, m);
    lit = '{3'b111};
    check_model("t5b_model", m, lit);
    send_frame(2, q, 1'b0);
    wait_drain();

    // T6: reset while the tail is being emitted
    q = '{1'b1, 1'b1};
    send_frame(0, q, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < NI; i++) expq[i].delete();
    @(negedge clk);
    chk("t6_in_reset", 0, {ov[0], ol[0], c0[0], c1[0]}, 4'b0000);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("t6_after", 0, {2'b00, ov[0], ir[0]}, 4'b0001);
    @(posedge clk); #1;
    q = '{1'b1};
    model_frame(0, q, m);
    lit = '{3'b110, 3'b010, 3'b111};
    check_model("t6_model", m, lit);
    send_frame(0, q, 1'b0);
    wait_drain();

    // Random frames on all configurations with random back-pressure and input gaps
    rnd_mode = 1'b1;
    fork
      rand_frames(0);
      rand_frames(1);
      rand_frames(2);
    join
    rnd_mode = 1'b0;
    wait_drain();
    repeat (5) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
